tff_bank_arbiter: RTL and testbench



---
 rtl/tff_bank_arbiter.sv | 178 +++++++++++++++++
 tb/tb_tff_bank_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tff_bank_arbiter.sv
// ----------------------------------------------------------------------------
// tff_bank_arbiter
// Round-robin arbiter sharing one WIDTH-bit toggle flip-flop register bank
// among NREQ requesters. A load drives the bank to a target value by
// converting it to a toggle mask (T = D ^ Q). A toggle applies the mask
// directly (T = D). Every transaction is IDLE -> APPLY -> RESP, which is
// three cycles. Completion reports the winning id and the popcount of T.
//
// Ports
//   clk         : clock, rising edge
//   reset       : asynchronous, active-high; clears all state
//   req_valid   : per-requester request valid            [NREQ]
//   req_mode    : per-requester kind, 0 = load, 1 = toggle [NREQ]
//   req_data    : requester i owns bits [i*WIDTH +: WIDTH] [NREQ*WIDTH]
//   req_ready   : one-hot grant, combinational, IDLE only [NREQ]
//   q           : register bank value                    [WIDTH]
//   busy        : FSM not in IDLE
//   done        : one-cycle completion pulse (RESP)
//   done_id     : completed requester id, valid with done [IDW]
//   toggle_cnt  : popcount of applied mask, valid with done [CNTW]
// ----------------------------------------------------------------------------
module tff_bank_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = $clog2(NREQ),
    parameter int unsigned CNTW  = $clog2(WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_mode,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        q,
    output logic                    busy,
    output logic                    done,
    output logic [IDW-1:0]          done_id,
    output logic [CNTW-1:0]         toggle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IDW-1:0]     r_ptr;
    logic [WIDTH-1:0]   r_data;
    logic               r_mode;
    logic [IDW-1:0]     r_id;
    logic [WIDTH-1:0]   r_q;
    logic               r_done;
    logic [IDW-1:0]     r_done_id;
    logic [CNTW-1:0]    r_cnt;

    logic               w_found;
    logic [IDW-1:0]     w_grant;
    logic [IDW-1:0]     w_ptr_nxt;
    logic [WIDTH-1:0]   w_sel_data;
    logic [WIDTH-1:0]   w_t;
    logic [CNTW-1:0]    w_cnt;

    // Round-robin search starting at the pointer; first valid requester wins.
    always_comb begin
        logic [IDW-1:0] idx;
        w_found = 1'b0;
        w_grant = '0;
        idx     = r_ptr;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_grant = idx;
            end
            idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + IDW'(1);
        end
    end

    // Pointer advances past the winner, wrapping modulo NREQ.
    assign w_ptr_nxt = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);

    // Data slice of the winning requester.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_grant == IDW'(i)) begin
                w_sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Toggle mask: load converts target to flips, toggle uses data as-is.
    assign w_t = r_mode ? r_data : (r_data ^ r_q);

    // Number of bits that will flip.
    always_comb begin
        w_cnt = '0;
        for (int b = 0; b < int'(WIDTH); b++) begin
            w_cnt = w_cnt + CNTW'(w_t[b]);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_APPLY;
            S_APPLY: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: grant only in IDLE; busy from the registered state.
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_found) begin
                req_ready = NREQ'(1) << w_grant;
            end
        end else begin
            busy = 1'b1;
        end
    end

    // Capture, bank update and completion registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr     <= '0;
            r_data    <= '0;
            r_mode    <= 1'b0;
            r_id      <= '0;
            r_q       <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_found) begin
                        r_data <= w_sel_data;
                        r_mode <= req_mode[w_grant];
                        r_id   <= w_grant;
                        r_ptr  <= w_ptr_nxt;
                    end
                end
                S_APPLY: begin
                    r_q       <= r_q ^ w_t;
                    r_cnt     <= w_cnt;
                    r_done_id <= r_id;
                    r_done    <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign q          = r_q;
    assign done       = r_done;
    assign done_id    = r_done_id;
    assign toggle_cnt = r_cnt;

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tff_bank_arbiter
// Directed, table-driven bench for tff_bank_arbiter (WIDTH=8, NREQ=4), plus
// hand-written sequences for held round-robin requests and mid-transaction
// reset.
// ----------------------------------------------------------------------------
module tb_tff_bank_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_mode;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  q;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [3:0]  toggle_cnt;

    int total;
    int bad;

    tff_bank_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_mode   (req_mode),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .toggle_cnt (toggle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  mode;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [7:0]  exp_q;
        logic [3:0]  exp_cnt;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] slot(input int i, input logic [7:0] d);
        return 32'(d) << (i * 8);
    endfunction

    // Drive one request at the current IDLE point and walk it to completion.
    task automatic run_vec(input vec_t v);
        req_valid = v.valid;
        req_mode  = v.mode;
        req_data  = v.data;
        #1;
        check("idle_ready", 32'(req_ready), 32'(v.exp_ready));
        check("idle_busy",  32'(busy), 32'd0);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        #1;
        check("apply_busy",  32'(busy), 32'd1);
        check("apply_ready", 32'(req_ready), 32'd0);
        check("apply_done",  32'(done), 32'd0);
        @(posedge clk); #1;
        check("resp_done", 32'(done), 32'd1);
        check("resp_q",    32'(q), 32'(v.exp_q));
        check("resp_cnt",  32'(toggle_cnt), 32'(v.exp_cnt));
        check("resp_id",   32'(done_id), 32'(v.exp_id));
        @(posedge clk); #1;
        check("back_idle_done", 32'(done), 32'd0);
        check("back_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_q;
        logic [1:0] order [5];
        vec_t       v;

        total = 0;
        bad   = 0;

        // {valid, mode, data, exp_ready, exp_q, exp_cnt, exp_id}
        vecs[0] = '{4'b0001, 4'b0000, slot(0, 8'hA5), 4'b0001, 8'hA5, 4'd4, 2'd0};
        vecs[1] = '{4'b0100, 4'b0100, slot(2, 8'h0F), 4'b0100, 8'hAA, 4'd4, 2'd2};
        vecs[2] = '{4'b0100, 4'b0000, slot(2, 8'hAA), 4'b0100, 8'hAA, 4'd0, 2'd2};
        vecs[3] = '{4'b1001, 4'b0001, slot(3, 8'h3C) | slot(0, 8'hFF), 4'b1000, 8'h3C, 4'd4, 2'd3};
        vecs[4] = '{4'b1001, 4'b1001, slot(3, 8'h00) | slot(0, 8'hFF), 4'b0001, 8'hC3, 4'd8, 2'd0};
        vecs[5] = '{4'b1001, 4'b1001, slot(3, 8'h00) | slot(0, 8'hFF), 4'b1000, 8'hC3, 4'd0, 2'd3};

        reset     = 1'b1;
        req_valid = 4'b0000;
        req_mode  = 4'b0000;
        req_data  = 32'd0;
        #1;
        check("rst_q",     32'(q), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_id",    32'(done_id), 32'd0);
        check("rst_cnt",   32'(toggle_cnt), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // All four held: grants 0,1,2,3,0 three cycles apart; q = C3 going in.
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        exp_q     = 8'hC3;
        req_valid = 4'b1111;
        req_mode  = 4'b1111;
        req_data  = {8'h08, 8'h04, 8'h02, 8'h01};
        #1;
        for (int g = 0; g < 5; g++) begin
            check("rr_ready", 32'(req_ready), 32'(4'b0001 << order[g]));
            check("rr_idle_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
            check("rr_apply_ready", 32'(req_ready), 32'd0);
            check("rr_apply_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
            exp_q = exp_q ^ (8'h01 << order[g]);
            check("rr_resp_ready", 32'(req_ready), 32'd0);
            check("rr_resp_busy", 32'(busy), 32'd1);
            check("rr_done", 32'(done), 32'd1);
            check("rr_id",   32'(done_id), 32'(order[g]));
            check("rr_q",    32'(q), 32'(exp_q));
            check("rr_cnt",  32'(toggle_cnt), 32'd1);
            @(posedge clk); #1;
        end
        req_valid = 4'b0000;
        #1;

        // Reset during APPLY: q clears at once, no done, pointer back to 0.
        req_valid = 4'b0001;
        req_mode  = 4'b0000;
        req_data  = slot(0, 8'h55);
        #1;
        check("pre_rst_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_q",    32'(q), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("mid_rst_hold_done", 32'(done), 32'd0);
            check("mid_rst_hold_q",    32'(q), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("post_rst_no_done", 32'(done), 32'd0);
        end
        v = '{4'b0110, 4'b0000, slot(1, 8'h77) | slot(2, 8'h11), 4'b0010, 8'h77, 4'd6, 2'd1};
        run_vec(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Grant must never be more than one-hot.
    always @(negedge clk) begin
        if (!reset) begin
            check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
